// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like responder: size encodings,
// the response-queue entry and a constant log2 helper.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

  // Countdown field is sized for LATENCY up to MAX_LATENCY.
  localparam int MAX_LATENCY = 256;
  localparam int CNT_W       = clog2(MAX_LATENCY);

  typedef struct packed {
    logic             is_write;
    logic [31:0]      rdata;
    logic [CNT_W-1:0] countdown;
  } resp_entry_t;

endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// In-order response FIFO; every stored entry counts down to zero each cycle
// and the head may only leave once its countdown has expired.
module resp_queue
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head_entry,
  output logic        head_ready,
  output logic        full
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] count_reg, count_next;
  resp_entry_t      slots_reg [DEPTH];
  logic             head_valid;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_reg == OCC_W'(DEPTH));
  assign head_valid = (count_reg != '0);
  assign head_entry = slots_reg[rd_ptr_reg];
  assign head_ready = head_valid && (head_entry.countdown == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && head_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Stale slots keep decrementing too; harmless since only valid ones are read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_ptr_reg == PTR_W'(i))) begin
        slots_reg[i] <= push_entry;
      end else if (slots_reg[i].countdown != '0) begin
        slots_reg[i].countdown <= slots_reg[i].countdown - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the sram-like req/addr_ok/data_ok interface, backed by a
// word-addressed memory and answering strictly in order after a minimum latency.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int OUTSTANDING = 4,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        addr_hold,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [31:0]       mem_array [2**MEM_AW];
  logic [MEM_AW-1:0] mem_idx;
  logic              accept;
  logic              queue_full;
  logic              head_ready;
  resp_entry_t       head_entry;
  resp_entry_t       push_entry;
  logic              unused_inputs;

  assign mem_idx = addr[MEM_AW+1:2];
  assign addr_ok = !reset && !addr_hold && !queue_full;
  assign accept  = req && addr_ok;

  // Reads sample the word at acceptance, so later writes cannot disturb them.
  assign push_entry.is_write  = wr;
  assign push_entry.rdata     = wr ? 32'd0 : mem_array[mem_idx];
  assign push_entry.countdown = CNT_W'(LATENCY - 1);

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_array[mem_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  resp_queue #(
    .DEPTH(OUTSTANDING)
  ) u_resp_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (data_ok),
    .head_entry (head_entry),
    .head_ready (head_ready),
    .full       (queue_full)
  );

  // Masked during reset so no stale response escapes while the queue is flushed.
  assign data_ok = !reset && head_ready;
  assign rdata   = data_ok ? head_entry.rdata : 32'd0;

  assign unused_inputs = ^{size, addr[31:MEM_AW+2], addr[1:0], head_entry.is_write};

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomized scoreboard bench for sram_like_responder: a driver feeds requests
// and a reference model; an independent monitor checks every response.
module tb_sram_like_responder;

  localparam int MAW = 12;
  localparam int OUT = 4;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        addr_hold = 1'b0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  sram_like_responder #(
    .MEM_AW      (MAW),
    .OUTSTANDING (OUT),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .addr_hold (addr_hold),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          acc_edge;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_pop = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] r;
    r = $urandom;
    r[MAW+1:2] = idx[MAW-1:0];
    return r;
  endfunction

  // One bus cycle: drive at the falling edge, then judge the handshake.
  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit h, input bit rst, output bit acc);
    int          idx;
    logic [31:0] word;
    bit          exp_ok;
    @(negedge clk);
    reset = rst; req = r; wr = w; addr = a; wdata = d; wstrb = s; addr_hold = h;
    size = 2'($urandom_range(0, 2));
    if (rst) begin
      sb.delete();
      last_pop = 0;
    end
    #1;
    exp_ok = !rst && !h && (sb.size() < OUT);
    check32("addr_ok", {31'd0, addr_ok}, {31'd0, exp_ok});
    acc = r && addr_ok && !rst;
    if (acc) begin
      idx = int'(a[MAW+1:2]);
      if (w) begin
        word = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
        for (int b = 0; b < 4; b++) if (s[b]) word[b*8 +: 8] = d[b*8 +: 8];
        mem_m[idx] = word;
        sb.push_back('{data: 32'd0, acc_edge: cyc + 1});
      end else begin
        sb.push_back('{data: mem_m[idx], acc_edge: cyc + 1});
      end
    end
  endtask

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acc;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 50) begin
      drive(1'b1, w, a, d, s, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no accept, required accept within 50 cycles");
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, acc);
      n++;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, acc);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  // Monitor: due pop edge = max(accept edge + LAT, previous pop edge + 1).
  initial begin
    exp_t e;
    int   due;
    bit   exp_dok;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check32("data_ok_in_reset", {31'd0, data_ok}, 32'd0);
        check32("rdata_in_reset", rdata, 32'd0);
      end else begin
        exp_dok = 1'b0;
        if (sb.size() != 0) begin
          due = sb[0].acc_edge + LAT;
          if (last_pop + 1 > due) due = last_pop + 1;
          exp_dok = (cyc + 1 >= due);
        end
        check32("data_ok", {31'd0, data_ok}, {31'd0, exp_dok});
        if (data_ok && sb.size() != 0) begin
          e = sb.pop_front();
          check32("rdata", rdata, e.data);
          $display("resp: accepted edge %0d, popped edge %0d, rdata %08h", e.acc_edge, cyc + 1, rdata);
          last_pop = cyc + 1;
        end else begin
          check32("rdata_idle", rdata, 32'd0);
        end
      end
    end
  end

  initial begin
    bit acc;
    repeat (3) drive(1'b1, 1'b0, 32'h10, 32'd0, 4'd0, 1'b0, 1'b1, acc);

    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    drain();
    send(1'b0, 32'h10, 32'd0, 4'd0);
    drain();
    send(1'b1, 32'h10, 32'h00AB0000, 4'b0100);
    send(1'b0, 32'h10, 32'd0, 4'd0);
    drain();
    send(1'b1, 32'h20, 32'h11111111, 4'hF);
    send(1'b0, 32'h20, 32'd0, 4'd0);
    drain();

    for (int i = 0; i < 16; i++) send(1'b1, mk_addr(i), $urandom, 4'hF);
    drain();

    // Six back-to-back reads with req held: fills the queue before the first pop.
    for (int i = 0; i < 6; i++) send(1'b0, mk_addr(i), 32'd0, 4'd0);
    drain();

    repeat (3) drive(1'b1, 1'b0, mk_addr(3), 32'd0, 4'd0, 1'b1, 1'b0, acc);
    drive(1'b1, 1'b0, mk_addr(3), 32'd0, 4'd0, 1'b0, 1'b0, acc);
    check32("accept_after_hold", {31'd0, acc}, 32'd1);
    drain();

    repeat (400) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), mk_addr($urandom_range(0, 15)),
            $urandom, 4'($urandom), $urandom_range(0, 9) == 0, 1'b0, acc);
    end
    drain();

    for (int i = 0; i < 3; i++) send(1'b0, mk_addr(i + 4), 32'd0, 4'd0);
    repeat (2) drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, acc);
    repeat (6) drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, acc);
    send(1'b0, 32'h10, 32'd0, 4'd0);
    send(1'b0, mk_addr(5), 32'd0, 4'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
